// File: rtl/topview_lines.sv
// Perspective-to-top-view line segment transform with a ping-pong line store.
// Segments pass a 5-stage arithmetic pipeline, then land in the active write bank.
module topview_lines #(
  parameter int IN_WIDTH      = 640,
  parameter int IN_HEIGHT     = 480,
  parameter int OUT_WIDTH     = 640,
  parameter int OUT_HEIGHT    = 480,
  parameter int DEPTH         = 1024,
  parameter int C0            = 0,
  parameter int C1            = 0,
  parameter int C2            = 0,
  parameter int C3            = 0,
  parameter int C4            = 0,
  parameter int C5            = 0,
  parameter int C6            = 0,
  parameter int CXP           = 0,
  parameter int DIV_W         = 32,
  parameter int STORE_INVALID = 0,
  localparam int H_W  = $clog2(IN_WIDTH),
  localparam int V_W  = $clog2(IN_HEIGHT),
  localparam int OH_W = $clog2(OUT_WIDTH),
  localparam int OV_W = $clog2(OUT_HEIGHT),
  localparam int A_W  = $clog2(DEPTH),
  localparam int DW   = 2 * (OV_W + OH_W) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_flag,
  input  logic            in_valid,
  input  logic [V_W-1:0]  in_start_v,
  input  logic [V_W-1:0]  in_end_v,
  input  logic [H_W-1:0]  in_start_h,
  input  logic [H_W-1:0]  in_end_h,
  input  logic [A_W-1:0]  raddr,
  input  logic            rd_release,
  output logic [DW-1:0]   rdata,
  output logic            ready,
  output logic [A_W:0]    line_num,
  output logic            overflow,
  output logic [15:0]     drop_cnt
);

  // 32-bit constant times (coordinate + sign bit), plus one bit of sum headroom
  localparam int MW = 34 + ((H_W > V_W) ? H_W : V_W);
  localparam int QW = (DIV_W > 32) ? DIV_W + 1 : 33;

  localparam logic signed [MW-1:0] K0 = MW'(C0);
  localparam logic signed [MW-1:0] K1 = MW'(C1);
  localparam logic signed [MW-1:0] K2 = MW'(C2);
  localparam logic signed [MW-1:0] K3 = MW'(C3);
  localparam logic signed [MW-1:0] K4 = MW'(C4);
  localparam logic signed [MW-1:0] K5 = MW'(C5);
  localparam logic signed [QW-1:0] K6 = QW'(C6);
  localparam logic signed [QW-1:0] KX = QW'(CXP);
  localparam logic signed [QW-1:0] LIM_H = QW'(OUT_WIDTH);
  localparam logic signed [QW-1:0] LIM_V = QW'(OUT_HEIGHT);
  localparam logic [A_W:0]         DEPTH_C = DEPTH[A_W:0];
  localparam logic                 STORE_KEEP = (STORE_INVALID != 0);

  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_WRITING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_READING = 2'd3;

  // ---------------- arithmetic pipeline (index 0 = start, 1 = end) ----------------
  logic [V_W-1:0]         in_v [2];
  logic [H_W-1:0]         in_h [2];
  logic signed [MW-1:0]   f0_q [2], f1_q [2], f2_q [2];
  logic signed [MW-1:0]   f0_d [2], f1_d [2], f2_d [2];
  logic signed [MW-1:0]   g0_q [2], g1_q [2], g2_q [2];
  logic signed [MW-1:0]   g0_d [2], g1_d [2], g2_d [2];
  logic signed [DIV_W-1:0] hq_q [2], vq_q [2], hq_d [2], vq_d [2];
  logic                   z3_q [2], z3_d [2], z4_q [2], z4_d [2];
  logic signed [QW-1:0]   oh_q [2], ov_q [2], oh_d [2], ov_d [2];
  logic                   ok [2];
  logic [DW-1:0]          word_q, word_d;
  logic                   segok_q, segok_d;
  logic [4:0]             flag_q, flag_d, valid_q, valid_d;

  always_comb begin
    in_v[0] = in_start_v;
    in_v[1] = in_end_v;
    in_h[0] = in_start_h;
    in_h[1] = in_end_h;
    for (int unsigned e = 0; e < 2; e++) begin
      f0_d[e] = K1 * MW'($signed({1'b0, in_v[e]}));
      f1_d[e] = K2 * MW'($signed({1'b0, in_h[e]}));
      f2_d[e] = K4 * MW'($signed({1'b0, in_v[e]}));
      g0_d[e] = K0 + f0_q[e];
      g1_d[e] = f1_q[e] - K3;
      g2_d[e] = f2_q[e] - K5;
      z3_d[e] = (g0_q[e] == '0);
      hq_d[e] = '0;
      vq_d[e] = '0;
      if (!z3_d[e]) begin
        hq_d[e] = DIV_W'(g1_q[e] / g0_q[e]);
        vq_d[e] = DIV_W'(g2_q[e] / g0_q[e]);
      end
      z4_d[e] = z3_q[e];
      oh_d[e] = QW'(hq_q[e]) + KX;
      ov_d[e] = QW'(vq_q[e]) + K6;
      ok[e]   = !z4_q[e] && !oh_q[e][QW-1] && (oh_q[e] < LIM_H)
                && !ov_q[e][QW-1] && (ov_q[e] < LIM_V);
    end
    segok_d = ok[0] & ok[1];
    word_d  = {ov_q[0][OV_W-1:0], oh_q[0][OH_W-1:0],
               ov_q[1][OV_W-1:0], oh_q[1][OH_W-1:0], segok_d};
    flag_d  = {flag_q[3:0], in_flag};
    valid_d = {valid_q[3:0], in_valid};
  end

  always_ff @(posedge clk) begin
    f0_q <= f0_d;  f1_q <= f1_d;  f2_q <= f2_d;
    g0_q <= g0_d;  g1_q <= g1_d;  g2_q <= g2_d;
    hq_q <= hq_d;  vq_q <= vq_d;  z3_q <= z3_d;
    oh_q <= oh_d;  ov_q <= ov_d;  z4_q <= z4_d;
    word_q  <= word_d;
    segok_q <= segok_d;
  end

  // ---------------- bank control ----------------
  logic [1:0]   bst_q [2], bst_d [2];
  logic [A_W:0] bcnt_q [2], bcnt_d [2];
  logic         bovf_q [2], bovf_d [2];
  logic         dflag_prev_q, dflag_prev_d;
  logic         wbank_q, wbank_d, accepted_q, accepted_d;
  logic [A_W:0] wcount_q, wcount_d;
  logic         ovf_pend_q, ovf_pend_d;
  logic         rbank_q, rbank_d, ready_q, ready_d, overflow_q, overflow_d;
  logic [A_W:0] line_num_q, line_num_d;
  logic [15:0]  drop_cnt_q, drop_cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic         rise, fall, acc, attempt, wr_en, wr_bank;
  logic [A_W:0] wcnt;
  logic [A_W-1:0] wr_addr;

  always_comb begin
    bst_d        = bst_q;
    bcnt_d       = bcnt_q;
    bovf_d       = bovf_q;
    rbank_d      = rbank_q;
    ready_d      = ready_q;
    line_num_d   = line_num_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    dflag_prev_d = flag_q[4];
    wr_bank      = wbank_q;
    acc          = accepted_q;
    wcnt         = wcount_q;
    ovf_pend_d   = ovf_pend_q;
    wr_en        = 1'b0;
    rise         = flag_q[4] & ~dflag_prev_q;
    fall         = ~flag_q[4] & dflag_prev_q;

    // Release and promotion look at registered state, so a bank committed on
    // the release edge is promoted one cycle later.
    if (rd_release && ready_q) begin
      bst_d[rbank_q] = ST_FREE;
      ready_d        = 1'b0;
    end else if (bst_q[0] != ST_READING && bst_q[1] != ST_READING) begin
      if (bst_q[0] == ST_FULL || bst_q[1] == ST_FULL) begin
        rbank_d        = (bst_q[0] == ST_FULL) ? 1'b0 : 1'b1;
        bst_d[rbank_d] = ST_READING;
        ready_d        = 1'b1;
        line_num_d     = bcnt_q[rbank_d];
        overflow_d     = bovf_q[rbank_d];
      end
    end

    if (rise) begin
      if (bst_q[0] == ST_FREE || bst_q[1] == ST_FREE) begin
        wr_bank        = (bst_q[0] == ST_FREE) ? 1'b0 : 1'b1;
        bst_d[wr_bank] = ST_WRITING;
        acc            = 1'b1;
        wcnt           = '0;
        ovf_pend_d     = 1'b0;
      end else begin
        acc = 1'b0;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    wr_addr  = wcnt[A_W-1:0];
    wcount_d = wcnt;
    attempt  = flag_q[4] & valid_q[4] & (segok_q | STORE_KEEP) & acc;
    if (attempt) begin
      if (wcnt < DEPTH_C) begin
        wr_en    = 1'b1;
        wcount_d = wcnt + 1'b1;
      end else begin
        ovf_pend_d = 1'b1;
      end
    end

    if (fall && accepted_q) begin
      bst_d[wbank_q]  = ST_FULL;
      bcnt_d[wbank_q] = wcount_q;
      bovf_d[wbank_q] = ovf_pend_q;
      acc             = 1'b0;
    end
    accepted_d = acc;
    wbank_d    = wr_bank;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        bst_q[i]  <= ST_FREE;
        bcnt_q[i] <= '0;
        bovf_q[i] <= 1'b0;
      end
      flag_q       <= '0;
      valid_q      <= '0;
      dflag_prev_q <= 1'b0;
      wbank_q      <= 1'b0;
      accepted_q   <= 1'b0;
      wcount_q     <= '0;
      ovf_pend_q   <= 1'b0;
      rbank_q      <= 1'b0;
      ready_q      <= 1'b0;
      line_num_q   <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      bst_q        <= bst_d;
      bcnt_q       <= bcnt_d;
      bovf_q       <= bovf_d;
      flag_q       <= flag_d;
      valid_q      <= valid_d;
      dflag_prev_q <= dflag_prev_d;
      wbank_q      <= wbank_d;
      accepted_q   <= accepted_d;
      wcount_q     <= wcount_d;
      ovf_pend_q   <= ovf_pend_d;
      rbank_q      <= rbank_d;
      ready_q      <= ready_d;
      line_num_q   <= line_num_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // ---------------- line storage ----------------
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  always_comb begin
    rdata_d = rbank_q ? mem1[raddr] : mem0[raddr];
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank) mem0[wr_addr] <= word_q;
    if (wr_en && wr_bank)  mem1[wr_addr] <= word_q;
    rdata_q <= rdata_d;
  end

  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign line_num = line_num_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/topview_lines.md
TOPVIEW_LINES -- requirements
Module: topview_lines

Interface
REQ-001 Param IN_WIDTH, 640, input image width; H_W = clog2(IN_WIDTH).
REQ-002 Param IN_HEIGHT, 480, input image height; V_W = clog2(IN_HEIGHT).
REQ-003 Param OUT_WIDTH, 640, top-view width; OH_W = clog2(OUT_WIDTH).
REQ-004 Param OUT_HEIGHT, 480, top-view height; OV_W = clog2(OUT_HEIGHT).
REQ-005 Param DEPTH, 1024, lines per bank, power of 2; A_W = clog2(DEPTH).
REQ-006 Params C0..C6, CXP: signed integer, 0, precomputed transform constants.
REQ-007 Param DIV_W, 32, quotient width.
REQ-008 Param STORE_INVALID, 0: 1 = store out-of-range lines with valid bit 0; 0 = drop them.
REQ-009 clk  in  1  single clock; all logic on rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 in_flag  in  1  frame active; falling edge ends frame.
REQ-012 in_valid  in  1  segment present this cycle (ignored when in_flag=0).
REQ-013 in_start_v, in_end_v  in  V_W  segment endpoint rows.
REQ-014 in_start_h, in_end_h  in  H_W  segment endpoint columns.
REQ-015 raddr  in  A_W  read address into read bank.
REQ-016 rd_release  in  1  one-cycle pulse: reader finished with read bank.
REQ-017 rdata  out  2*(OV_W+OH_W)+1  {sv, sh, ev, eh, valid}, one cycle after raddr.
REQ-018 ready  out  1  read bank holds a committed frame.
REQ-019 line_num  out  A_W+1  line count of committed read-bank frame.
REQ-020 overflow  out  1  committed frame exceeded DEPTH lines.
REQ-021 drop_cnt  out  16  frames dropped since reset, saturating.

Function
REQ-022 Transform per endpoint, four registered stages: f0=C1*v, f1=C2*h, f2=C4*v; g0=C0+f0, g1=f1-C3, g2=f2-C5; hq=g1/g0, vq=g2/g0 (signed, truncate toward zero); oh=hq+CXP, ov=vq+C6.
REQ-023 Intermediate widths sized from constants so no overflow over full input range.
REQ-024 g0==0 for either endpoint forces segment invalid; divider output then don't-care.
REQ-025 Segment valid iff both endpoints satisfy 0<=oh<OUT_WIDTH and 0<=ov<OUT_HEIGHT and REQ-024 clear; stored coordinates are low OV_W/OH_W bits.
REQ-026 Latency: segment sampled at edge t written to write bank at edge t+5; in_flag/in_valid delayed 5 stages alongside.
REQ-027 Write enable = delayed flag & delayed valid & (valid | STORE_INVALID) & wcount<DEPTH & bank accepted; waddr = wcount, then wcount+1.
REQ-028 wcount reaching DEPTH: further writes dropped, overflow-pending set; no wrap.
REQ-029 Two banks, ping-pong; state per bank FREE, WRITING, FULL, READING.
REQ-030 Delayed-flag rising edge: if a FREE bank exists it becomes WRITING, wcount=0; else frame dropped (no writes), drop_cnt+1.
REQ-031 Delayed-flag falling edge on WRITING bank: bank FULL, stored count and overflow-pending latched.
REQ-032 FULL bank with no READING bank becomes READING next cycle; ready=1, line_num/overflow updated same cycle.
REQ-033 rd_release while READING: bank FREE next cycle, ready=0; rd_release with ready=0 ignored.
REQ-034 Simultaneous release and commit: release first, commit same edge; FULL bank promotes next cycle.
REQ-035 Zero-line frame commits with line_num=0, ready=1.
REQ-036 Read: raddr registered, rdata from read bank; raddr>=line_num gives stale data, no error.

Reset
REQ-037 rst: both banks FREE, ready=0, line_num=0, overflow=0, drop_cnt=0, wcount=0, delay pipeline flags cleared; RAM contents not cleared.
REQ-038 rst mid-frame abandons frame; next rising in_flag starts fresh, no drop counted.

Verification
REQ-039 Identity constants (C1=0,C0=1,C2=1,C3=0,C4=1,C5=0,C6=0,CXP=0), one segment (10,20)-(30,40) -> written at t+5; after flag falls ready=1, line_num=1, rdata={10,20,30,40,1}.
REQ-040 Segment with oh=OUT_WIDTH, STORE_INVALID=0 -> not stored, line_num=0; STORE_INVALID=1 -> line_num=1, valid bit 0.
REQ-041 DEPTH+3 valid segments in one frame -> line_num=DEPTH, overflow=1, last address holds line DEPTH-1.
REQ-042 Three frames, no rd_release -> third dropped, drop_cnt=1; after release second frame readable, ready=1.
REQ-043 rst asserted mid-frame at line 5 -> ready=0, line_num=0; next frame of 2 lines commits line_num=2.
REQ-044 C0 chosen so g0=0 for v=7 -> segment invalid and not stored.
